// File: rtl/i2c_trans_ctrl_pkg.sv
// Shared definitions for the I2C transaction sequencer:
// control-word bit positions, byte-engine commands, FSM states.
package i2c_trans_ctrl_pkg;

    localparam int CTL_ABORT   = 11;
    localparam int CTL_EN      = 10;
    localparam int CTL_BEGIN   = 9;
    localparam int CTL_RW      = 8;
    localparam int CTL_HOLD    = 7;
    localparam int CTL_CNT_MSB = 5;

    typedef enum logic [1:0] {
        CMD_START = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_READ  = 2'b10,
        CMD_STOP  = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_WRITE,
        S_READ,
        S_END,
        S_STOP,
        S_DONE
    } state_t;

endpackage

// File: rtl/i2c_trans_ctrl_if.sv
// Command handshake between the transaction sequencer (master)
// and the I2C byte engine (slave).
interface i2c_trans_ctrl_if;

    logic       cmd_valid;
    logic [1:0] cmd_type;
    logic [7:0] cmd_wdata;
    logic       cmd_mack;
    logic       cmd_done;
    logic       ack_in;
    logic [7:0] rd_byte;

    modport master (
        output cmd_valid,
        output cmd_type,
        output cmd_wdata,
        output cmd_mack,
        input  cmd_done,
        input  ack_in,
        input  rd_byte
    );

    modport slave (
        input  cmd_valid,
        input  cmd_type,
        input  cmd_wdata,
        input  cmd_mack,
        output cmd_done,
        output ack_in,
        output rd_byte
    );

endinterface

// File: rtl/i2c_trans_ctrl.sv
// I2C transaction sequencer: turns the control word into
// START/ADDR/data/STOP byte commands and moves FIFO payload.
module i2c_trans_ctrl
    import i2c_trans_ctrl_pkg::*;
#(
    parameter int MAX_BIT = 11,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [MAX_BIT:0]   control,
    input  logic [6:0]         slave_addr,
    output logic               clear_begin_trans,
    i2c_trans_ctrl_if.master   eng,
    input  logic               tx_empty,
    input  logic [7:0]         tx_data,
    output logic               tx_rd_en,
    input  logic               rx_full,
    output logic               rx_wr_en,
    output logic [7:0]         rx_wdata,
    output logic               busy,
    output logic               trans_done,
    output logic               nack_error,
    output logic               aborted
);

    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    cmd_t             type_q, type_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             mack_q, mack_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rw_q, rw_d;
    logic             hold_q, hold_d;
    logic [6:0]       addr_q, addr_d;
    logic             abort_q, abort_d;

    logic             fire;
    logic [CNT_W-1:0] cnt_dec;
    logic             unused_rsvd;

    assign unused_rsvd = control[6];

    assign eng.cmd_valid = valid_q;
    assign eng.cmd_type  = type_q;
    assign eng.cmd_wdata = wdata_q;
    assign eng.cmd_mack  = mack_q;

    assign busy     = (state_q != S_IDLE);
    assign fire     = valid_q & eng.cmd_done;
    assign cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
    assign rx_wdata = rx_wr_en ? eng.rd_byte : 8'h00;

    // Next-state, command issue and status pulse decode
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        type_d  = type_q;
        wdata_d = wdata_q;
        mack_d  = mack_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        hold_d  = hold_q;
        addr_d  = addr_q;
        abort_d = abort_q;

        clear_begin_trans = 1'b0;
        tx_rd_en          = 1'b0;
        rx_wr_en          = 1'b0;
        nack_error        = 1'b0;
        trans_done        = 1'b0;
        aborted           = 1'b0;

        if (state_q != S_IDLE &&
            (control[CTL_ABORT] || !control[CTL_EN]))
            abort_d = 1'b1;

        if (fire)
            valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (control[CTL_EN] && control[CTL_BEGIN]) begin
                    clear_begin_trans = 1'b1;
                    if (control[CTL_ABORT]) begin
                        aborted = 1'b1;
                    end else begin
                        rw_d    = control[CTL_RW];
                        hold_d  = control[CTL_HOLD];
                        cnt_d   = CNT_W'(control[CTL_CNT_MSB:0]);
                        addr_d  = slave_addr;
                        state_d = S_START;
                        valid_d = 1'b1;
                        type_d  = CMD_START;
                        wdata_d = 8'h00;
                        mack_d  = 1'b0;
                    end
                end
            end

            S_START: begin
                if (fire)
                    state_d = S_ADDR;
            end

            S_ADDR: begin
                if (fire) begin
                    if (!eng.ack_in) begin
                        nack_error = 1'b1;
                        state_d    = S_STOP;
                    end else if (cnt_q == '0) begin
                        state_d = S_END;
                    end else begin
                        state_d = rw_q ? S_READ : S_WRITE;
                    end
                end else if (!valid_q) begin
                    if (abort_q) begin
                        state_d = S_STOP;
                    end else begin
                        valid_d = 1'b1;
                        type_d  = CMD_WRITE;
                        wdata_d = {addr_q, rw_q};
                        mack_d  = 1'b0;
                    end
                end
            end

            S_WRITE: begin
                if (fire) begin
                    tx_rd_en = 1'b1;
                    cnt_d    = cnt_dec;
                    if (!eng.ack_in) begin
                        nack_error = 1'b1;
                        state_d    = S_STOP;
                    end else if (cnt_dec == '0) begin
                        state_d = S_END;
                    end
                end else if (!valid_q) begin
                    if (abort_q) begin
                        state_d = S_STOP;
                    end else if (!tx_empty) begin
                        valid_d = 1'b1;
                        type_d  = CMD_WRITE;
                        wdata_d = tx_data;
                        mack_d  = 1'b0;
                    end
                end
            end

            S_READ: begin
                if (fire) begin
                    rx_wr_en = 1'b1;
                    cnt_d    = cnt_dec;
                    if (cnt_dec == '0)
                        state_d = S_END;
                end else if (!valid_q) begin
                    if (abort_q) begin
                        state_d = S_STOP;
                    end else if (!rx_full) begin
                        valid_d = 1'b1;
                        type_d  = CMD_READ;
                        wdata_d = 8'h00;
                        mack_d  = (cnt_q != CNT_W'(1));
                    end
                end
            end

            S_END: begin
                state_d = (hold_q && !abort_q) ? S_DONE : S_STOP;
            end

            S_STOP: begin
                if (fire) begin
                    state_d = S_DONE;
                end else if (!valid_q) begin
                    valid_d = 1'b1;
                    type_d  = CMD_STOP;
                    wdata_d = 8'h00;
                    mack_d  = 1'b0;
                end
            end

            S_DONE: begin
                aborted    = abort_q;
                trans_done = !abort_q;
                abort_d    = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    // State, command and latched transaction registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            type_q  <= CMD_START;
            wdata_q <= 8'h00;
            mack_q  <= 1'b0;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            hold_q  <= 1'b0;
            addr_q  <= 7'h00;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            type_q  <= type_d;
            wdata_q <= wdata_d;
            mack_q  <= mack_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            hold_q  <= hold_d;
            addr_q  <= addr_d;
            abort_q <= abort_d;
        end
    end

endmodule
